// File: rtl/hyperram_resp_model_if.sv
// hyperram_resp_model_if: HyperBus-style host/device link signals (DQ, RWDS, CS#, clock enable)
interface hyperram_resp_model_if;
  logic        csn;
  logic        ck_en;
  logic [15:0] dq_in;
  logic        dq_valid;
  logic        rwds_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rwds_out;
  logic        rwds_oe;
  modport master (output csn, ck_en, dq_in, dq_valid, rwds_in, input dq_out, dq_oe, rwds_out, rwds_oe);
  modport slave (input csn, ck_en, dq_in, dq_valid, rwds_in, output dq_out, dq_oe, rwds_out, rwds_oe);
endinterface

// File: rtl/hyperram_resp_model.sv
// hyperram_resp_model: device-side HyperBus responder with CA decode, latency count, word memory and CR0
module hyperram_resp_model #(
  parameter int          ADDR_W  = 8,
  parameter int          LATENCY = 12,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] ID1_VAL = 16'h0001,
  parameter logic [15:0] CR0_RST = 16'h8F1F
) (
  input  logic                 clk,
  input  logic                 rst,
  hyperram_resp_model_if.slave bus,
  output logic [15:0]          cr0
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {IDLE, CA, LAT, RD, WR, REGW, WAITCS} state_t;
  state_t          state_q, state_d;
  logic [31:0]     ca_q, ca_d, addr_q, addr_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rw_q, rw_d, as_q, as_d, tog_q, tog_d;
  logic [15:0]     cr0_q, cr0_d, reg_rd, mem_rd;
  logic [15:0]     mem [DEPTH];
  logic            cap, last_ca, lat_done, mem_we, wr_step, unused_ok;
  // a word arriving on the same edge as csn rising never lands anywhere
  assign cap      = state_q == CA && bus.dq_valid && !bus.csn;
  assign last_ca  = cap && wcnt_q == 2'd2;
  assign lat_done = state_q == LAT && cnt_q == CW'(LATENCY - 1);
  assign wr_step  = state_q == WR && bus.dq_valid && !bus.csn;
  assign mem_we   = wr_step && !bus.rwds_in;
  assign unused_ok = ^{bus.ck_en, ca_q[29]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ca_q    <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      as_q    <= 1'b0;
      tog_q   <= 1'b1;
      cr0_q   <= CR0_RST;
    end else begin
      state_q <= state_d;
      ca_q    <= ca_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      as_q    <= as_d;
      tog_q   <= tog_d;
      cr0_q   <= cr0_d;
    end
  end
  always_ff @(posedge clk) if (mem_we) mem[addr_q[ADDR_W-1:0]] <= bus.dq_in;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = CA;
      CA:      state_d = last_ca ? ((!ca_q[31] && ca_q[30]) ? REGW : LAT) : CA;
      LAT:     state_d = lat_done ? (rw_q ? RD : WR) : LAT;
      REGW:    state_d = bus.dq_valid ? WAITCS : REGW;
      default: state_d = state_q;
    endcase
    if (bus.csn) state_d = IDLE;
  end
  // ca_q holds {word0, word1}; word2 is decoded straight from the bus
  always_comb begin
    ca_d   = cap ? {ca_q[15:0], bus.dq_in} : ca_q;
    wcnt_d = state_q == IDLE ? 2'd0 : wcnt_q + 2'(cap);
    rw_d   = last_ca ? ca_q[31] : rw_q;
    as_d   = last_ca ? ca_q[30] : as_q;
    addr_d = last_ca ? {ca_q[28:0], bus.dq_in[2:0]} :
             (state_q == RD && !as_q) || wr_step ? addr_q + 32'd1 : addr_q;
    cnt_d  = state_q == LAT ? cnt_q + CW'(1) : '0;
    tog_d  = state_q == RD ? ~tog_q : 1'b1;
    cr0_d  = state_q == REGW && bus.dq_valid && !bus.csn && addr_q == 32'h800 ? bus.dq_in : cr0_q;
  end
  always_comb begin
    mem_rd       = mem[addr_q[ADDR_W-1:0]];
    reg_rd       = addr_q == 32'h0 ? ID0_VAL : addr_q == 32'h1 ? ID1_VAL :
                   addr_q == 32'h800 ? cr0_q : 16'h0000;
    bus.dq_oe    = state_q == RD;
    bus.dq_out   = state_q == RD ? (as_q ? reg_rd : mem_rd) : 16'h0000;
    bus.rwds_oe  = state_q == CA || (state_q == LAT && rw_q) || state_q == RD;
    bus.rwds_out = state_q == RD ? tog_q : bus.rwds_oe;
    cr0          = cr0_q;
  end
endmodule

// File: tb/tb_hyperram_resp_model.sv
// tb_hyperram_resp_model: directed host transactions with a queued scoreboard checking every driven read word
module tb_hyperram_resp_model;
  localparam int L = 12;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cr0;
  int          checks = 0;
  int          failures = 0;
  logic [16:0] exp_q [$];
  logic [16:0] e;
  logic [16:0] wq [$];
  logic [15:0] eq [$];
  hyperram_resp_model_if bus();
  hyperram_resp_model #(.ADDR_W(8), .LATENCY(L)) dut (.clk(clk), .rst(rst_n), .bus(bus), .cr0(cr0));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // opens a transaction and sends the three CA words with one skipped cycle after word0
  task automatic start(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    bus.csn = 1'b0;
    tick;
    chk("rwds_release", {bus.rwds_oe, bus.rwds_out}, 2'b11);
    bus.dq_valid = 1'b1; bus.dq_in = w0; tick;
    bus.dq_valid = 1'b0; bus.dq_in = 16'hDEAD; tick;
    bus.dq_valid = 1'b1; bus.dq_in = w1; tick;
    bus.dq_in = w2; tick;
    bus.dq_valid = 1'b0;
  endtask
  task automatic wr(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                    input logic [16:0] d [$], input bit cs_last);
    start(w0, w1, w2);
    chk("wr_lat_rwds_oe", bus.rwds_oe, 1'b0);
    bus.dq_valid = 1'b1; bus.dq_in = 16'hBAD0;
    repeat (L) tick;
    foreach (d[i]) begin
      bus.dq_in = d[i][15:0]; bus.rwds_in = d[i][16]; bus.dq_valid = 1'b1;
      if (cs_last && i == d.size() - 1) bus.csn = 1'b1;
      tick;
    end
    bus.dq_valid = 1'b0; bus.rwds_in = 1'b0; bus.csn = 1'b1;
    tick;
    chk("wr_end_oe", {bus.dq_oe, bus.rwds_oe}, 2'b00);
  endtask
  task automatic rd(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] d [$]);
    foreach (d[i]) exp_q.push_back({(i % 2 == 0), d[i]});
    start(w0, w1, w2);
    chk("rd_lat_rwds", {bus.rwds_oe, bus.rwds_out, bus.dq_oe}, 3'b110);
    repeat (L + d.size() - 1) tick;
    bus.csn = 1'b1;
    tick;
    chk("rd_end_dq_oe", bus.dq_oe, 1'b0);
    chk("rd_drained", exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (bus.dq_oe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected actual=%h required=none", {bus.rwds_out, bus.dq_out});
      end else begin
        e = exp_q.pop_front();
        if ({bus.rwds_out, bus.dq_out} !== e) begin
          failures++;
          $display("FAIL rd_word actual=%h required=%h", {bus.rwds_out, bus.dq_out}, e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    bus.csn = 1'b1; bus.ck_en = 1'b1; bus.dq_in = 16'h0; bus.dq_valid = 1'b0; bus.rwds_in = 1'b0;
    #12;
    chk("reset_out", {bus.dq_oe, bus.rwds_oe, bus.rwds_out, bus.dq_out}, 19'h0);
    chk("reset_cr0", cr0, 16'h8F1F);
    rst_n = 1'b1;
    tick; tick;
    chk("idle_oe", {bus.dq_oe, bus.rwds_oe}, 2'b00);
    wq = '{17'h01111, 17'h02222, 17'h03333, 17'h04444};
    wr(16'h0000, 16'h0000, 16'h0003, wq, 1'b0);
    eq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rd(16'h8000, 16'h0000, 16'h0003, eq);
    wq = '{17'h05A5A};
    wr(16'h0000, 16'h001F, 16'h0007, wq, 1'b0);
    wq = '{17'h0AAAA, 17'h1BBBB, 17'h0CCCC};
    wr(16'h0000, 16'h001F, 16'h0006, wq, 1'b0);
    eq = '{16'hAAAA, 16'h5A5A, 16'hCCCC};
    rd(16'h8000, 16'h001F, 16'h0006, eq);
    wq = '{17'h01357, 17'h02468};
    wr(16'h0000, 16'h0002, 16'h0000, wq, 1'b0);
    wq = '{17'h09999, 17'h08888};
    wr(16'h0000, 16'h0002, 16'h0000, wq, 1'b1);
    eq = '{16'h9999, 16'h2468};
    rd(16'h8000, 16'h0002, 16'h0000, eq);
    start(16'h4000, 16'h0100, 16'h0000);
    bus.dq_in = 16'h8F17; bus.dq_valid = 1'b1; tick;
    chk("regw_cr0", cr0, 16'h8F17);
    bus.dq_in = 16'h1234; tick;
    chk("waitcs_cr0", cr0, 16'h8F17);
    bus.dq_valid = 1'b0; bus.csn = 1'b1; tick;
    start(16'h4000, 16'h0000, 16'h0001);
    bus.dq_in = 16'hFFFF; bus.dq_valid = 1'b1; tick;
    bus.dq_valid = 1'b0; bus.csn = 1'b1; tick;
    chk("regw_other_cr0", cr0, 16'h8F17);
    eq = '{16'h0C81, 16'h0C81};
    rd(16'hC000, 16'h0000, 16'h0000, eq);
    eq = '{16'h0001};
    rd(16'hC000, 16'h0000, 16'h0001, eq);
    eq = '{16'h8F17};
    rd(16'hC000, 16'h0100, 16'h0000, eq);
    bus.csn = 1'b0; tick;
    bus.dq_valid = 1'b1; bus.dq_in = 16'h0000; tick;
    bus.dq_in = 16'h0000; tick;
    bus.dq_valid = 1'b0; bus.csn = 1'b1; tick;
    chk("abort_oe", {bus.dq_oe, bus.rwds_oe}, 2'b00);
    eq = '{16'h1111, 16'h2222};
    rd(16'h8000, 16'h0000, 16'h0003, eq);
    exp_q.push_back({1'b1, 16'h1111});
    start(16'h8000, 16'h0000, 16'h0003);
    repeat (L) tick;
    chk("pre_reset_dq_oe", bus.dq_oe, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_oe", {bus.dq_oe, bus.rwds_oe}, 2'b00);
    chk("async_reset_cr0", cr0, 16'h8F1F);
    bus.csn = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
    chk("reset_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
